// File: rtl/interrupt_arbiter.sv
// Interrupt/exception arbiter: picks the highest-priority source and holds a handler-entry request until acknowledged.
// Optional build macro INTERRUPT_SYNCHRONIZER_EN adds a 2-flop synchronizer in front of pendingInterrupts.
module interrupt_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] irqLines,
    input  logic [15:0] interruptMask,
    input  logic        interruptEnable,
    input  logic        exceptionRequest,
    input  logic [4:0]  exceptionCode,
    output logic        handlerEntryRequest,
    input  logic        handlerEntryAcknowledge,
    // "priority" is a reserved word, so the PSW priorityWriteValue source is named priorityLevel.
    output logic [4:0]  priorityLevel,
    output logic [15:0] pendingInterrupts
);

    // Handshake: handlerEntryRequest rises with priorityLevel valid and both stay frozen until the
    // cycle handlerEntryAcknowledge is high; the request drops on the following edge.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SETTLE  = 2'd2
    } arbState;

    arbState     state;
    arbState     stateNext;
    logic        requestNext;
    logic [4:0]  priorityNext;
    logic [15:0] sampledIrq;
    logic [15:0] eligible;
    logic [3:0]  irqSelect;
    logic        irqPresent;

`ifdef INTERRUPT_SYNCHRONIZER_EN
    logic [15:0] syncStage1;
    logic [15:0] syncStage2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            syncStage1 <= '0;
            syncStage2 <= '0;
        end else begin
            syncStage1 <= irqLines;
            syncStage2 <= syncStage1;
        end
    end

    assign sampledIrq = syncStage2;
`else
    assign sampledIrq = irqLines;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pendingInterrupts <= '0;
        end else begin
            pendingInterrupts <= sampledIrq;
        end
    end

    assign eligible   = interruptEnable ? (pendingInterrupts & interruptMask) : 16'h0000;
    assign irqPresent = |eligible;

    // Ascending scan so the highest-numbered eligible line wins.
    always_comb begin
        irqSelect = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (eligible[i]) begin
                irqSelect = 4'(i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            handlerEntryRequest <= 1'b0;
            priorityLevel       <= 5'd0;
        end else begin
            state               <= stateNext;
            handlerEntryRequest <= requestNext;
            priorityLevel       <= priorityNext;
        end
    end

    always_comb begin
        stateNext    = state;
        requestNext  = handlerEntryRequest;
        priorityNext = priorityLevel;
        case (state)
            IDLE: begin
                requestNext = 1'b0;
                // Exceptions bypass IE and the mask; a losing interrupt stays pending for later.
                if (exceptionRequest) begin
                    stateNext    = REQUEST;
                    requestNext  = 1'b1;
                    priorityNext = exceptionCode;
                end else if (irqPresent) begin
                    stateNext    = REQUEST;
                    requestNext  = 1'b1;
                    priorityNext = {1'b0, irqSelect};
                end
            end
            REQUEST: begin
                if (handlerEntryAcknowledge) begin
                    stateNext   = SETTLE;
                    requestNext = 1'b0;
                end
            end
            SETTLE: begin
                // One quiet cycle lets the PSW IE/priority update reach the eligibility logic.
                stateNext   = IDLE;
                requestNext = 1'b0;
            end
            default: begin
                stateNext   = IDLE;
                requestNext = 1'b0;
            end
        endcase
    end

endmodule
